// File: rtl/mem_wb_pkg.sv
// Shared Wishbone cycle-type codes and state encoding for the SDRAM controller's burst master.
package mem_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, WR, RD} wbm_state_t;

  // Single-beat bursts are classic cycles; longer bursts flag only their last beat as end-of-burst.
  function automatic logic [2:0] beat_cti(input logic single, input logic final_beat);
    if (single) return CTI_CLASSIC;
    return final_beat ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_burst_master.sv
// Converts valid/ready burst requests into Wishbone incrementing bursts (sys_clk domain).
// Optional ack watchdog enabled by defining WB_ACK_TIMEOUT_EN.
module wb_burst_master
  import mem_wb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 26,
  parameter int BLW         = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              sys_clk,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic              req_we,
  input  logic [BLW-1:0]    req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wsel,
  output logic              rdata_valid,
  output logic [DW-1:0]     rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i
);

  localparam logic [AW-1:0] ADDR_STEP = AW'(DW / 8);

  wbm_state_t     state;
  logic [BLW-1:0] len;
  logic [BLW-1:0] beat_cnt;
  logic [BLW:0]   beats_loaded;
  logic           beat_done;
  logic           final_beat;
  logic           wr_load;
  logic           timeout;

  assign beat_done  = wb_stb_o && wb_ack_i;
  assign final_beat = beat_done && (beat_cnt == len);
  assign req_ready  = (state == IDLE) && !RESET;
  assign busy       = (state != IDLE);
  // In WR, wb_stb_o doubles as the "output register full" flag; a completing beat frees it.
  assign wdata_ready = (state == WR) && (beats_loaded <= {1'b0, len}) && (!wb_stb_o || beat_done);
  assign wr_load     = wdata_valid && wdata_ready;

`ifdef WB_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = wb_stb_o && !wb_ack_i && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      state        <= IDLE;
      len          <= '0;
      beat_cnt     <= '0;
      beats_loaded <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_addr_o    <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_cti_o     <= CTI_CLASSIC;
      rdata_valid  <= 1'b0;
      rdata        <= '0;
      rdata_last   <= 1'b0;
      err          <= 1'b0;
`ifdef WB_ACK_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      err         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            len          <= req_len;
            beat_cnt     <= '0;
            beats_loaded <= '0;
            wb_addr_o    <= req_addr;
            wb_we_o      <= req_we;
            wb_cyc_o     <= 1'b1;
            if (req_we) begin
              state <= WR;
            end else begin
              state    <= RD;
              wb_stb_o <= 1'b1;
              wb_sel_o <= '1;
              wb_cti_o <= beat_cti(req_len == '0, 1'b0);
            end
          end
        end
        WR: begin
          if (wr_load) begin
            wb_stb_o     <= 1'b1;
            wb_dat_o     <= wdata;
            wb_sel_o     <= wsel;
            wb_cti_o     <= beat_cti(len == '0, beats_loaded == {1'b0, len});
            beats_loaded <= beats_loaded + (BLW + 1)'(1);
          end else if (beat_done) begin
            wb_stb_o <= 1'b0;
          end
          if (beat_done) begin
            beat_cnt  <= beat_cnt + BLW'(1);
            wb_addr_o <= wb_addr_o + ADDR_STEP;
          end
          if (final_beat) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= IDLE;
          end
        end
        RD: begin
          if (beat_done) begin
            rdata_valid <= 1'b1;
            rdata       <= wb_dat_i;
            rdata_last  <= final_beat;
            beat_cnt    <= beat_cnt + BLW'(1);
            wb_addr_o   <= wb_addr_o + ADDR_STEP;
            wb_cti_o    <= beat_cti(len == '0, (beat_cnt + BLW'(1)) == len);
          end
          if (final_beat) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef WB_ACK_TIMEOUT_EN
      // Watchdog counts only stalled strobes; an abandoned burst never reports rdata_last.
      if (state == IDLE || beat_done) to_cnt <= '0;
      else if (wb_stb_o && !wb_ack_i) to_cnt <= to_cnt + TW'(1);
      if (timeout) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        err      <= 1'b1;
        state    <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: the bench acts as a Wishbone slave with a byte-addressed
// memory model and random ack latency, and predicts every beat from the burst rules directly.
module tb_wb_burst_master;

  logic        sys_clk = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic [25:0] req_addr;
  logic        req_we;
  logic [4:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        busy;
  logic        err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  int nVectors = 0;
  int nMiscompares = 0;
  logic [31:0] mem [int];
  bit validPat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 sys_clk = ~sys_clk;

  wb_burst_master #(.TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wsel(wsel),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last), .busy(busy), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  // Every comparison funnels through here so the summary counts stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Step to just after the next rising edge so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] memRead(input logic [25:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {6'b0, a} ^ 32'hC3A5_0000;
  endfunction

  task automatic memWrite(input logic [25:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = memRead(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[int'(a)] = w;
  endtask

  // Runs one burst as requester and slave; validMode 0=always valid, 1=fixed gap pattern, 2=random.
  // resetAt >= 0 fires RESET while that beat index is on the bus.
  task automatic applyStimulus(input logic [25:0] startAddr, input int len, input logic isWrite,
                               input int validMode, input int maxLat, input int resetAt, input bit fixedFirst);
    logic [31:0] wList[$];
    logic [3:0]  sList[$];
    int loaded, acked, cycles, waitCnt, waitTarget;
    logic prevRd, prevLast, ackNow, accept, stbNow, expReady;
    logic [31:0] prevData, beatData;
    logic [25:0] beatAddr;
    logic [2:0]  expCti;
    bit done;
    for (int i = 0; i <= len + 1; i++) begin
      wList.push_back($urandom);
      sList.push_back(4'($urandom));
    end
    if (fixedFirst) begin
      wList[0] = 32'hDEADBEEF;
      sList[0] = 4'hF;
    end
    req_addr = startAddr; req_len = 5'(len); req_we = isWrite; req_valid = 1'b1;
    checkOutput("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    loaded = 0; acked = 0; cycles = 0; waitCnt = 0; waitTarget = $urandom_range(0, maxLat);
    prevRd = 0; prevLast = 0; prevData = 0; done = 0;
    while (!done && cycles < 1000) begin
      checkOutput("rdata_valid", rdata_valid, prevRd);
      if (prevRd) begin
        checkOutput("rdata", rdata, prevData);
        checkOutput("rdata_last", rdata_last, prevLast);
      end
      checkOutput("cyc_held", wb_cyc_o, 1);
      checkOutput("req_ready_busy", req_ready, 0);
      checkOutput("stb", wb_stb_o, isWrite ? (loaded > acked) : 1'b1);
      stbNow = wb_stb_o;
      beatAddr = startAddr + 26'(4 * acked);
      if (stbNow) begin
        expCti = (len == 0) ? 3'b000 : ((acked == len) ? 3'b111 : 3'b010);
        checkOutput("addr", wb_addr_o, beatAddr);
        checkOutput("cti", wb_cti_o, expCti);
        checkOutput("we", wb_we_o, isWrite);
        checkOutput("sel", wb_sel_o, isWrite ? sList[acked] : 4'hF);
        if (isWrite) checkOutput("wdat", wb_dat_o, wList[acked]);
      end
      if (resetAt >= 0 && acked == resetAt && stbNow) begin
        RESET = 1'b1; wb_ack_i = 1'b0; wdata_valid = 1'b0;
        tick();
        RESET = 1'b0;
        checkOutput("cyc_after_reset", wb_cyc_o, 0);
        checkOutput("stb_after_reset", wb_stb_o, 0);
        for (int k = 0; k < 4; k++) begin
          checkOutput("rdata_valid_after_reset", rdata_valid, 0);
          checkOutput("rdata_last_after_reset", rdata_last, 0);
          checkOutput("busy_after_reset", busy, 0);
          tick();
        end
        return;
      end
      ackNow = stbNow && (waitCnt >= waitTarget);
      beatData = memRead(beatAddr);
      wb_ack_i = ackNow;
      wb_dat_i = (ackNow && !isWrite) ? beatData : 32'h0;
      accept = 1'b0;
      if (isWrite) begin
        case (validMode)
          0: wdata_valid = 1'b1;
          1: wdata_valid = (cycles < 6) ? validPat[cycles] : 1'b1;
          default: wdata_valid = 1'($urandom_range(0, 1));
        endcase
        wdata = wList[loaded];
        wsel  = sList[loaded];
        #1;
        expReady = (loaded <= len) && (loaded == acked || ackNow);
        checkOutput("wdata_ready", wdata_ready, expReady);
        accept = wdata_valid && wdata_ready;
      end
      tick();
      if (accept) loaded++;
      prevRd = ackNow && !isWrite;
      prevData = beatData;
      if (ackNow) begin
        if (isWrite) memWrite(beatAddr, wList[acked], sList[acked]);
        acked++;
        waitCnt = 0;
        waitTarget = $urandom_range(0, maxLat);
      end else if (stbNow) begin
        waitCnt++;
      end
      prevLast = (acked == len + 1);
      if (acked == len + 1) done = 1;
      cycles++;
    end
    wb_ack_i = 1'b0; wdata_valid = 1'b0;
    if (!done) checkOutput("burst_cycle_budget", 0, 1);
    checkOutput("rdata_valid_final", rdata_valid, prevRd);
    if (prevRd) begin
      checkOutput("rdata_final", rdata, prevData);
      checkOutput("rdata_last_final", rdata_last, 1);
    end
    checkOutput("cyc_end", wb_cyc_o, 0);
    checkOutput("stb_end", wb_stb_o, 0);
    checkOutput("req_ready_end", req_ready, 1);
    checkOutput("busy_end", busy, 0);
    checkOutput("err_quiet", err, 0);
    if (isWrite) checkOutput("beats_loaded", loaded, len + 1);
    tick();
    checkOutput("rdata_valid_idle", rdata_valid, 0);
    checkOutput("cyc_idle_gap", wb_cyc_o, 0);
  endtask

  initial begin
    int stallCycles;
    logic [25:0] a;
    RESET = 1'b1; req_valid = 0; req_addr = 0; req_we = 0; req_len = 0;
    wdata_valid = 0; wdata = 0; wsel = 0; wb_ack_i = 0; wb_dat_i = 0;
    tick(); tick();
    checkOutput("rst_cyc", wb_cyc_o, 0);
    checkOutput("rst_stb", wb_stb_o, 0);
    checkOutput("rst_sel", wb_sel_o, 0);
    checkOutput("rst_cti", wb_cti_o, 0);
    checkOutput("rst_addr", wb_addr_o, 0);
    checkOutput("rst_rdata_valid", rdata_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_wdata_ready", wdata_ready, 0);
    RESET = 1'b0;
    tick();
    checkOutput("idle_req_ready", req_ready, 1);

    applyStimulus(26'h100, 0, 1'b1, 0, 0, -1, 1'b1);
    applyStimulus(26'h100, 0, 1'b0, 0, 0, -1, 1'b0);
    checkOutput("single_write_mem", memRead(26'h100), 32'hDEADBEEF);
    applyStimulus(26'h200, 7, 1'b0, 0, 0, -1, 1'b0);
    applyStimulus(26'h300, 3, 1'b1, 1, 0, -1, 1'b0);
    applyStimulus(26'h1000, 15, 1'b0, 0, 5, -1, 1'b0);
    applyStimulus(26'h1000, 15, 1'b1, 2, 5, -1, 1'b0);
    applyStimulus(26'h1000, 15, 1'b0, 0, 5, -1, 1'b0);
    applyStimulus(26'h3FFFFF8, 3, 1'b0, 0, 0, -1, 1'b0);
    applyStimulus(26'h400, 7, 1'b0, 0, 0, 2, 1'b0);
    applyStimulus(26'h400, 1, 1'b0, 0, 1, -1, 1'b0);

    for (int n = 0; n < 10; n++) begin
      a = 26'($urandom) & 26'h3FFFFFC;
      applyStimulus(a, $urandom_range(0, 31), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), -1, 1'b0);
    end

`ifdef WB_ACK_TIMEOUT_EN
    req_addr = 26'h500; req_len = 5'd3; req_we = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    stallCycles = 0;
    for (int n = 0; n < 200 && wb_cyc_o; n++) begin
      if (wb_stb_o) stallCycles++;
      tick();
    end
    checkOutput("timeout_stalls", stallCycles, 16);
    checkOutput("timeout_err_pulse", err, 1);
    checkOutput("timeout_no_last", rdata_last, 0);
    tick();
    checkOutput("timeout_err_clear", err, 0);
`else
    stallCycles = 0;
    checkOutput("err_tied_low", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
